// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I/M control: combinational D-stage decode feeding a registered E stage.
// A down-counter holds a divide in E for DIV_LATENCY cycles and raises Busy_o meanwhile.
module pipe_ctrl_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int M_EXT       = 1,
  parameter int DIV_LATENCY = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] Instr_i,
  input  logic                  InstrValid_i,
  input  logic                  Stall_i,
  input  logic                  Flush_i,
  input  logic                  Zero_i,
  input  logic                  LessS_i,
  input  logic                  LessU_i,
  output logic [2:0]            ImmSrcD_o,
  output logic                  ValidE_o,
  output logic                  RegWriteE_o,
  output logic                  MemWriteE_o,
  output logic [1:0]            ResultSrcE_o,
  output logic [4:0]            ALUCtrlE_o,
  output logic [1:0]            ALUSrcAE_o,
  output logic                  ALUSrcBE_o,
  output logic [1:0]            MemTypeE_o,
  output logic                  MemSignE_o,
  output logic                  JumpE_o,
  output logic                  BranchE_o,
  output logic [2:0]            Funct3E_o,
  output logic                  IllegalE_o,
  output logic                  PCSrcE_o,
  output logic                  Busy_o
);

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLTU = 5'b00110;
  localparam logic [4:0] ALU_SRL  = 5'b00111;
  localparam logic [4:0] ALU_SLL  = 5'b01000;
  localparam logic [4:0] ALU_SRA  = 5'b01001;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [4:0] alu_ctrl;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [1:0] mem_type;
    logic       mem_sign;
    logic       jump;
    logic       branch;
    logic [2:0] funct3;
    logic       illegal;
  } e_reg_t;

  e_reg_t     dec, e_d, e_q;
  logic       dec_illegal, dec_is_div;
  logic [2:0] imm_src;
  logic [7:0] div_cnt_d, div_cnt_q;
  logic       cond;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr;

  assign opcode       = Instr_i[6:0];
  assign funct3       = Instr_i[14:12];
  assign funct7       = Instr_i[31:25];
  assign unused_instr = ^{Instr_i[24:15], Instr_i[11:7]};

  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt,
                                          input logic sub_ok);
    case (f3)
      3'b000:  base_alu = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  // byte 01, half 10, word 00
  function automatic logic [1:0] mem_type(input logic [1:0] sz);
    case (sz)
      2'b00:   mem_type = 2'b01;
      2'b01:   mem_type = 2'b10;
      default: mem_type = 2'b00;
    endcase
  endfunction

  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.funct3    = funct3;
    dec.alu_ctrl  = ALU_ADD;
    dec_illegal   = 1'b0;
    dec_is_div    = 1'b0;
    imm_src       = 3'b000;
    case (opcode)
      7'd3: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src_b  = 1'b1;
        dec.mem_type   = mem_type(funct3[1:0]);
        dec.mem_sign   = funct3[2];
        dec_illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'd19: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_ctrl  = base_alu(funct3, funct7[5], 1'b0);
      end
      7'd23: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 2'b01;
        dec.alu_src_b = 1'b1;
        imm_src       = 3'b011;
      end
      7'd35: begin
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.mem_type  = mem_type(funct3[1:0]);
        imm_src       = 3'b001;
      end
      7'd51: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (M_EXT != 0) begin
            dec.alu_ctrl = {1'b1, 1'b0, funct3};
            dec_is_div   = funct3[2];
          end else begin
            dec_illegal  = 1'b1;
          end
        end else begin
          dec.alu_ctrl = base_alu(funct3, funct7[5], 1'b1);
        end
      end
      7'd55: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 2'b10;
        dec.alu_src_b = 1'b1;
        imm_src       = 3'b011;
      end
      7'd99: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        dec_illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
        imm_src      = 3'b010;
      end
      7'd103: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.alu_src_b  = 1'b1;
      end
      7'd111: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.alu_src_a  = 2'b01;
        dec.alu_src_b  = 1'b1;
        imm_src        = 3'b100;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign ImmSrcD_o = imm_src;
  assign Busy_o    = (div_cnt_q != 8'd0);

  // Flush beats hold; the countdown keeps running under Stall_i.
  always_comb begin
    e_d       = e_q;
    div_cnt_d = Busy_o ? (div_cnt_q - 8'd1) : 8'd0;
    if (Flush_i) begin
      e_d       = '0;
      div_cnt_d = 8'd0;
    end else if (Stall_i || Busy_o) begin
      e_d = e_q;
    end else if (!InstrValid_i) begin
      e_d = '0;
    end else if (dec_illegal) begin
      e_d         = '0;
      e_d.illegal = 1'b1;
    end else begin
      e_d = dec;
      if (dec_is_div) div_cnt_d = 8'(DIV_LATENCY - 1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_q       <= '0;
      div_cnt_q <= 8'd0;
    end else begin
      e_q       <= e_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    case (e_q.funct3)
      3'b000:  cond = Zero_i;
      3'b001:  cond = !Zero_i;
      3'b100:  cond = LessS_i;
      3'b101:  cond = !LessS_i;
      3'b110:  cond = LessU_i;
      3'b111:  cond = !LessU_i;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE_o     = e_q.valid & (e_q.jump | (e_q.branch & cond));
  assign ValidE_o     = e_q.valid;
  assign RegWriteE_o  = e_q.reg_write;
  assign MemWriteE_o  = e_q.mem_write;
  assign ResultSrcE_o = e_q.result_src;
  assign ALUCtrlE_o   = e_q.alu_ctrl;
  assign ALUSrcAE_o   = e_q.alu_src_a;
  assign ALUSrcBE_o   = e_q.alu_src_b;
  assign MemTypeE_o   = e_q.mem_type;
  assign MemSignE_o   = e_q.mem_sign;
  assign JumpE_o      = e_q.jump;
  assign BranchE_o    = e_q.branch;
  assign Funct3E_o    = e_q.funct3;
  assign IllegalE_o   = e_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expected E-stage words are queued as each
// instruction is driven and popped against the DUT one edge later.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid, stall, flush, zero, less_s, less_u;

  logic [2:0] imm_src;
  logic       valid_e, reg_write_e, mem_write_e, alu_src_b_e, mem_sign_e;
  logic       jump_e, branch_e, illegal_e, pc_src_e, busy;
  logic [1:0] result_src_e, alu_src_a_e, mem_type_e;
  logic [4:0] alu_ctrl_e;
  logic [2:0] funct3_e;

  logic [2:0] nm_imm_src;
  logic       nm_valid_e, nm_reg_write_e, nm_mem_write_e, nm_alu_src_b_e, nm_mem_sign_e;
  logic       nm_jump_e, nm_branch_e, nm_illegal_e, nm_pc_src_e, nm_busy;
  logic [1:0] nm_result_src_e, nm_alu_src_a_e, nm_mem_type_e;
  logic [4:0] nm_alu_ctrl_e;
  logic [2:0] nm_funct3_e;

  int n_vec  = 0;
  int n_miss = 0;

  logic [21:0] exp_q[$];
  logic        busy_q[$];
  logic [21:0] e_vec;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.DATA_WIDTH(32), .M_EXT(1), .DIV_LATENCY(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .Instr_i(instr), .InstrValid_i(instr_valid),
    .Stall_i(stall), .Flush_i(flush), .Zero_i(zero), .LessS_i(less_s), .LessU_i(less_u),
    .ImmSrcD_o(imm_src), .ValidE_o(valid_e), .RegWriteE_o(reg_write_e),
    .MemWriteE_o(mem_write_e), .ResultSrcE_o(result_src_e), .ALUCtrlE_o(alu_ctrl_e),
    .ALUSrcAE_o(alu_src_a_e), .ALUSrcBE_o(alu_src_b_e), .MemTypeE_o(mem_type_e),
    .MemSignE_o(mem_sign_e), .JumpE_o(jump_e), .BranchE_o(branch_e),
    .Funct3E_o(funct3_e), .IllegalE_o(illegal_e), .PCSrcE_o(pc_src_e), .Busy_o(busy)
  );

  pipe_ctrl_unit #(.DATA_WIDTH(32), .M_EXT(0), .DIV_LATENCY(8)) u_dut_nm (
    .clk_i(clk), .rst_i(rst), .Instr_i(instr), .InstrValid_i(instr_valid),
    .Stall_i(stall), .Flush_i(flush), .Zero_i(zero), .LessS_i(less_s), .LessU_i(less_u),
    .ImmSrcD_o(nm_imm_src), .ValidE_o(nm_valid_e), .RegWriteE_o(nm_reg_write_e),
    .MemWriteE_o(nm_mem_write_e), .ResultSrcE_o(nm_result_src_e), .ALUCtrlE_o(nm_alu_ctrl_e),
    .ALUSrcAE_o(nm_alu_src_a_e), .ALUSrcBE_o(nm_alu_src_b_e), .MemTypeE_o(nm_mem_type_e),
    .MemSignE_o(nm_mem_sign_e), .JumpE_o(nm_jump_e), .BranchE_o(nm_branch_e),
    .Funct3E_o(nm_funct3_e), .IllegalE_o(nm_illegal_e), .PCSrcE_o(nm_pc_src_e), .Busy_o(nm_busy)
  );

  assign e_vec = {valid_e, reg_write_e, mem_write_e, result_src_e, alu_ctrl_e, alu_src_a_e,
                  alu_src_b_e, mem_type_e, mem_sign_e, jump_e, branch_e, funct3_e, illegal_e};

  function automatic logic [21:0] ev(input logic v, input logic rw, input logic mw,
                                     input logic [1:0] rs, input logic [4:0] alu,
                                     input logic [1:0] a, input logic b, input logic [1:0] mt,
                                     input logic ms, input logic j, input logic br,
                                     input logic [2:0] f3, input logic ill);
    return {v, rw, mw, rs, alu, a, b, mt, ms, j, br, f3, ill};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] i, input logic v, input logic st,
                      input logic fl, input logic [21:0] exp, input logic exp_busy);
    instr = i; instr_valid = v; stall = st; flush = fl;
    exp_q.push_back(exp);
    busy_q.push_back(exp_busy);
    @(posedge clk);
    #1;
    check_val({tag, " e_reg"}, 32'(e_vec), 32'(exp_q.pop_front()));
    check_val({tag, " busy"}, 32'(busy), 32'(busy_q.pop_front()));
    flush = 1'b0; stall = 1'b0;
  endtask

  localparam logic [31:0] I_ADD   = 32'h002081B3, I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_BEQ   = 32'h00208463, I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_BGEU  = 32'h0020F463, I_BBAD = 32'h0020A463;
  localparam logic [31:0] I_DIV   = 32'h0220C1B3, I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_LUI   = 32'h123452B7, I_AUIPC = 32'h00001197;
  localparam logic [31:0] I_LW    = 32'h0000A183, I_LBU  = 32'h0000C183;
  localparam logic [31:0] I_LH    = 32'h00009183, I_LBAD = 32'h0000B183;
  localparam logic [31:0] I_SW    = 32'h0020A023, I_SB   = 32'h00208023;
  localparam logic [31:0] I_SRAI  = 32'h4010D193, I_ADDI = 32'h40008193;
  localparam logic [31:0] I_JAL   = 32'h008000EF, I_JALR = 32'h00008067;
  localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;

  logic [21:0] e_add, e_sub, e_beq, e_blt, e_bgeu, e_div, e_mul, e_lui, e_auipc;
  logic [21:0] e_lw, e_lbu, e_lh, e_sw, e_sb, e_srai, e_addi, e_jal, e_jalr, e_ill;

  initial begin
    e_add   = ev(1,1,0,2'b00,5'b00000,2'b00,0,2'b00,0,0,0,3'b000,0);
    e_sub   = ev(1,1,0,2'b00,5'b00001,2'b00,0,2'b00,0,0,0,3'b000,0);
    e_beq   = ev(1,0,0,2'b00,5'b00001,2'b00,0,2'b00,0,0,1,3'b000,0);
    e_blt   = ev(1,0,0,2'b00,5'b00001,2'b00,0,2'b00,0,0,1,3'b100,0);
    e_bgeu  = ev(1,0,0,2'b00,5'b00001,2'b00,0,2'b00,0,0,1,3'b111,0);
    e_div   = ev(1,1,0,2'b00,5'b10100,2'b00,0,2'b00,0,0,0,3'b100,0);
    e_mul   = ev(1,1,0,2'b00,5'b10000,2'b00,0,2'b00,0,0,0,3'b000,0);
    e_lui   = ev(1,1,0,2'b00,5'b00000,2'b10,1,2'b00,0,0,0,3'b101,0);
    e_auipc = ev(1,1,0,2'b00,5'b00000,2'b01,1,2'b00,0,0,0,3'b001,0);
    e_lw    = ev(1,1,0,2'b01,5'b00000,2'b00,1,2'b00,0,0,0,3'b010,0);
    e_lbu   = ev(1,1,0,2'b01,5'b00000,2'b00,1,2'b01,1,0,0,3'b100,0);
    e_lh    = ev(1,1,0,2'b01,5'b00000,2'b00,1,2'b10,0,0,0,3'b001,0);
    e_sw    = ev(1,0,1,2'b00,5'b00000,2'b00,1,2'b00,0,0,0,3'b010,0);
    e_sb    = ev(1,0,1,2'b00,5'b00000,2'b00,1,2'b01,0,0,0,3'b000,0);
    e_srai  = ev(1,1,0,2'b00,5'b01001,2'b00,1,2'b00,0,0,0,3'b101,0);
    e_addi  = ev(1,1,0,2'b00,5'b00000,2'b00,1,2'b00,0,0,0,3'b000,0);
    e_jal   = ev(1,1,0,2'b10,5'b00000,2'b01,1,2'b00,0,1,0,3'b000,0);
    e_jalr  = ev(1,1,0,2'b10,5'b00000,2'b00,1,2'b00,0,1,0,3'b000,0);
    e_ill   = ev(0,0,0,2'b00,5'b00000,2'b00,0,2'b00,0,0,0,3'b000,1);

    rst = 1'b1; instr = 32'h0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    zero = 1'b0; less_s = 1'b0; less_u = 1'b0;
    #12;
    check_val("reset e_reg", 32'(e_vec), 32'h0);
    check_val("reset pcsrc", 32'(pc_src_e), 32'h0);
    check_val("reset busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    step("add", I_ADD, 1, 0, 0, e_add, 0);

    instr = I_BEQ; #1;
    check_val("immsrc beq", 32'(imm_src), 32'h2);
    step("beq", I_BEQ, 1, 0, 0, e_beq, 0);
    zero = 1'b1; #1; check_val("beq taken", 32'(pc_src_e), 32'h1);
    zero = 1'b0; #1; check_val("beq not taken", 32'(pc_src_e), 32'h0);
    step("blt", I_BLT, 1, 0, 0, e_blt, 0);
    less_s = 1'b1; #1; check_val("blt taken", 32'(pc_src_e), 32'h1);
    less_s = 1'b0;
    step("bgeu", I_BGEU, 1, 0, 0, e_bgeu, 0);
    less_u = 1'b1; #1; check_val("bgeu lt", 32'(pc_src_e), 32'h0);
    less_u = 1'b0; #1; check_val("bgeu ge", 32'(pc_src_e), 32'h1);

    step("sub", I_SUB, 1, 0, 0, e_sub, 0);
    step("srai", I_SRAI, 1, 0, 0, e_srai, 0);
    step("addi f7", I_ADDI, 1, 0, 0, e_addi, 0);
    step("auipc", I_AUIPC, 1, 0, 0, e_auipc, 0);
    step("lw", I_LW, 1, 0, 0, e_lw, 0);
    step("lbu", I_LBU, 1, 0, 0, e_lbu, 0);
    step("lh", I_LH, 1, 0, 0, e_lh, 0);
    step("sw", I_SW, 1, 0, 0, e_sw, 0);
    step("sb", I_SB, 1, 0, 0, e_sb, 0);
    step("mul", I_MUL, 1, 0, 0, e_mul, 0);
    step("add after mul", I_ADD, 1, 0, 0, e_add, 0);
    step("jalr", I_JALR, 1, 0, 0, e_jalr, 0);

    instr = I_JAL; #1;
    check_val("immsrc jal", 32'(imm_src), 32'h4);
    step("jal", I_JAL, 1, 0, 0, e_jal, 0);
    #1; check_val("jal pcsrc", 32'(pc_src_e), 32'h1);

    step("load f3 011", I_LBAD, 1, 0, 0, e_ill, 0);
    #1; check_val("illegal pcsrc", 32'(pc_src_e), 32'h0);
    step("branch f3 010", I_BBAD, 1, 0, 0, e_ill, 0);
    step("invalid slot", I_ONES, 0, 0, 0, 22'h0, 0);

    step("div load", I_DIV, 1, 0, 0, e_div, 1);
    check_val("div m_ext0", 32'({nm_valid_e, nm_illegal_e}), 32'h1);
    for (int k = 1; k <= 7; k++) step("div hold", I_ADD, 1, 0, 0, e_div, (k < 7));
    step("after div", I_ADD, 1, 0, 0, e_add, 0);

    step("div2 load", I_DIV, 1, 0, 0, e_div, 1);
    step("div2 c2", I_ADD, 1, 0, 0, e_div, 1);
    step("div2 c3", I_ADD, 1, 0, 0, e_div, 1);
    step("div2 flush", I_ADD, 1, 0, 1, 22'h0, 0);
    step("after flush", I_ADD, 1, 0, 0, e_add, 0);
    step("flush+stall", I_ADD, 1, 1, 1, 22'h0, 0);

    instr = I_LUI; #1;
    check_val("immsrc lui", 32'(imm_src), 32'h3);
    step("lui", I_LUI, 1, 0, 0, e_lui, 0);
    step("lui stall1", I_ADD, 1, 1, 0, e_lui, 0);
    step("lui stall2", I_ADD, 1, 1, 0, e_lui, 0);
    step("after stall", I_ADD, 1, 0, 0, e_add, 0);

    step("div3 load", I_DIV, 1, 0, 0, e_div, 1);
    for (int k = 1; k <= 7; k++) step("div3 stalled", I_ADD, 1, 1, 0, e_div, (k < 7));
    step("after div3", I_ADD, 1, 0, 0, e_add, 0);

    step("all ones", I_ONES, 1, 0, 0, e_ill, 0);
    step("div4 load", I_DIV, 1, 0, 0, e_div, 1);
    step("div4 c2", I_ADD, 1, 0, 0, e_div, 1);
    #2 rst = 1'b1;
    #1;
    check_val("async rst e_reg", 32'(e_vec), 32'h0);
    check_val("async rst busy", 32'(busy), 32'h0);
    check_val("async rst pcsrc", 32'(pc_src_e), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step("post rst", I_ADD, 1, 0, 0, e_add, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
